// File: rtl/rvfi_mon_pkg.sv
// Shared types, error codes and helpers for the RVFI commit-stream monitor.
package rvfi_mon_pkg;

  localparam logic [15:0] ERR_NONE     = 16'd0;
  localparam logic [15:0] ERR_ORDER    = 16'd101;
  localparam logic [15:0] ERR_PC       = 16'd102;
  localparam logic [15:0] ERR_RS1      = 16'd103;
  localparam logic [15:0] ERR_RS2      = 16'd104;
  localparam logic [15:0] ERR_X0       = 16'd105;
  localparam logic [15:0] ERR_HALTED   = 16'd106;
  localparam logic [15:0] ERR_MEM_MASK = 16'd107;
  localparam logic [15:0] ERR_PC_ALIGN = 16'd108;
  localparam logic [15:0] ERR_INSN     = 16'd109;
  localparam logic [15:0] ERR_TRAP     = 16'd110;

  // One retire lane, restricted to the fields the monitor actually checks.
  typedef struct {
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        halt;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
  } lane_t;

  // Byte masks a naturally aligned byte, halfword or word access can produce.
  function automatic logic mask_legal(input logic [3:0] mask);
    logic ok;
    case (mask)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rvfi_mon_lane_check.sv
// Combinational check of a single retire lane; consumes the monitor state as left by
// lower lanes and produces the state seen by the next lane.
module rvfi_mon_lane_check
  import rvfi_mon_pkg::*;
(
  input  lane_t              i_lane,
  input  logic [63:0]        i_order,
  input  logic               i_first,
  input  logic [31:0]        i_last_pc,
  input  logic               i_halted,
  input  logic [31:0][31:0]  i_shadow,
  input  logic [31:0]        i_shadow_vld,
  output logic [15:0]        o_err,
  output logic [63:0]        o_order,
  output logic               o_first,
  output logic [31:0]        o_last_pc,
  output logic               o_halted,
  output logic [31:0][31:0]  o_shadow,
  output logic [31:0]        o_shadow_vld
);

  logic w_rs1_bad;
  logic w_rs2_bad;
  logic w_x0_bad;
  logic w_mask_bad;
  logic w_unused_insn;

  assign w_unused_insn = ^i_lane.insn[15:2];

  assign w_rs1_bad = (i_lane.rs1_addr != 5'd0) && i_shadow_vld[i_lane.rs1_addr] &&
                     (i_lane.rs1_rdata != i_shadow[i_lane.rs1_addr]);
  assign w_rs2_bad = (i_lane.rs2_addr != 5'd0) && i_shadow_vld[i_lane.rs2_addr] &&
                     (i_lane.rs2_rdata != i_shadow[i_lane.rs2_addr]);
  assign w_x0_bad  = ((i_lane.rd_addr  == 5'd0) && (i_lane.rd_wdata  != 32'd0)) ||
                     ((i_lane.rs1_addr == 5'd0) && (i_lane.rs1_rdata != 32'd0)) ||
                     ((i_lane.rs2_addr == 5'd0) && (i_lane.rs2_rdata != 32'd0));
  assign w_mask_bad = ((i_lane.mem_rmask != 4'd0) && (i_lane.mem_wmask != 4'd0)) ||
                      !mask_legal(i_lane.mem_rmask) || !mask_legal(i_lane.mem_wmask);

  always_comb begin
    o_err        = ERR_NONE;
    o_order      = i_order;
    o_first      = i_first;
    o_last_pc    = i_last_pc;
    o_halted     = i_halted;
    o_shadow     = i_shadow;
    o_shadow_vld = i_shadow_vld;

    if (i_lane.valid) begin
      if (i_lane.order != i_order) begin
        o_err = ERR_ORDER;
      end else if (!i_first && (i_lane.pc_rdata != i_last_pc)) begin
        o_err = ERR_PC;
      end else if (w_rs1_bad) begin
        o_err = ERR_RS1;
      end else if (w_rs2_bad) begin
        o_err = ERR_RS2;
      end else if (w_x0_bad) begin
        o_err = ERR_X0;
      end else if (i_halted) begin
        o_err = ERR_HALTED;
      end else if (w_mask_bad) begin
        o_err = ERR_MEM_MASK;
      end else if (i_lane.pc_rdata[0] || i_lane.pc_wdata[0]) begin
        o_err = ERR_PC_ALIGN;
      end else if ((i_lane.insn[1:0] != 2'b11) && (i_lane.insn[31:16] != 16'd0)) begin
        // A compressed encoding must leave the upper halfword zero.
        o_err = ERR_INSN;
      end else if (i_lane.trap) begin
        o_err = ERR_TRAP;
      end

      // State always advances, so a single fault does not cascade into later ones.
      o_order   = i_lane.order + 64'd1;
      o_last_pc = i_lane.pc_wdata;
      o_first   = 1'b0;
      o_halted  = i_halted | i_lane.halt;
      if (i_lane.rd_addr != 5'd0) begin
        o_shadow[i_lane.rd_addr]     = i_lane.rd_wdata;
        o_shadow_vld[i_lane.rd_addr] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvfi_monitor_rv32imc.sv
// RVFI commit-stream checker: chains one lane checker per retire channel and latches
// the first violation as a sticky error code.
module rvfi_monitor_rv32imc
  import rvfi_mon_pkg::*;
#(
  parameter int unsigned NRET = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [64*NRET-1:0]   rvfi_order,
  input  logic [32*NRET-1:0]   rvfi_insn,
  input  logic [NRET-1:0]      rvfi_trap,
  input  logic [NRET-1:0]      rvfi_halt,
  input  logic [NRET-1:0]      rvfi_intr,
  input  logic [2*NRET-1:0]    rvfi_mode,
  input  logic [5*NRET-1:0]    rvfi_rs1_addr,
  input  logic [5*NRET-1:0]    rvfi_rs2_addr,
  input  logic [5*NRET-1:0]    rvfi_rd_addr,
  input  logic [32*NRET-1:0]   rvfi_rs1_rdata,
  input  logic [32*NRET-1:0]   rvfi_rs2_rdata,
  input  logic [32*NRET-1:0]   rvfi_rd_wdata,
  input  logic [32*NRET-1:0]   rvfi_pc_rdata,
  input  logic [32*NRET-1:0]   rvfi_pc_wdata,
  input  logic [32*NRET-1:0]   rvfi_mem_addr,
  input  logic [4*NRET-1:0]    rvfi_mem_rmask,
  input  logic [4*NRET-1:0]    rvfi_mem_wmask,
  input  logic [32*NRET-1:0]   rvfi_mem_rdata,
  input  logic [32*NRET-1:0]   rvfi_mem_wdata,
  input  logic [NRET-1:0]      rvfi_mem_extamo,
  output logic [15:0]          errcode
);

  logic [63:0]       r_order;
  logic              r_first;
  logic [31:0]       r_last_pc;
  logic              r_halted;
  logic [31:0][31:0] r_shadow;
  logic [31:0]       r_shadow_vld;
  logic [15:0]       r_errcode;

  lane_t             w_lane     [NRET];
  logic [15:0]       w_lane_err [NRET];
  logic [15:0]       w_err;
  logic              w_unused;

  assign w_unused = ^{rvfi_intr, rvfi_mode, rvfi_mem_extamo, rvfi_mem_addr,
                      rvfi_mem_rdata, rvfi_mem_wdata};

  always_comb begin
    for (int k = 0; k < NRET; k++) begin
      w_lane[k].valid     = rvfi_valid[k];
      w_lane[k].order     = rvfi_order[k*64 +: 64];
      w_lane[k].insn      = rvfi_insn[k*32 +: 32];
      w_lane[k].trap      = rvfi_trap[k];
      w_lane[k].halt      = rvfi_halt[k];
      w_lane[k].rs1_addr  = rvfi_rs1_addr[k*5 +: 5];
      w_lane[k].rs2_addr  = rvfi_rs2_addr[k*5 +: 5];
      w_lane[k].rd_addr   = rvfi_rd_addr[k*5 +: 5];
      w_lane[k].rs1_rdata = rvfi_rs1_rdata[k*32 +: 32];
      w_lane[k].rs2_rdata = rvfi_rs2_rdata[k*32 +: 32];
      w_lane[k].rd_wdata  = rvfi_rd_wdata[k*32 +: 32];
      w_lane[k].pc_rdata  = rvfi_pc_rdata[k*32 +: 32];
      w_lane[k].pc_wdata  = rvfi_pc_wdata[k*32 +: 32];
      w_lane[k].mem_rmask = rvfi_mem_rmask[k*4 +: 4];
      w_lane[k].mem_wmask = rvfi_mem_wmask[k*4 +: 4];
    end
  end

  // Each lane block owns its chained state; lane k reads lane k-1's outputs by name.
  for (genvar k = 0; k < NRET; k++) begin : g_lane
    logic [63:0]       w_order_in;
    logic              w_first_in;
    logic [31:0]       w_last_pc_in;
    logic              w_halted_in;
    logic [31:0][31:0] w_shadow_in;
    logic [31:0]       w_shadow_vld_in;
    logic [63:0]       w_order_out;
    logic              w_first_out;
    logic [31:0]       w_last_pc_out;
    logic              w_halted_out;
    logic [31:0][31:0] w_shadow_out;
    logic [31:0]       w_shadow_vld_out;

    if (k == 0) begin : g_head
      assign w_order_in      = r_order;
      assign w_first_in      = r_first;
      assign w_last_pc_in    = r_last_pc;
      assign w_halted_in     = r_halted;
      assign w_shadow_in     = r_shadow;
      assign w_shadow_vld_in = r_shadow_vld;
    end else begin : g_tail
      assign w_order_in      = g_lane[k-1].w_order_out;
      assign w_first_in      = g_lane[k-1].w_first_out;
      assign w_last_pc_in    = g_lane[k-1].w_last_pc_out;
      assign w_halted_in     = g_lane[k-1].w_halted_out;
      assign w_shadow_in     = g_lane[k-1].w_shadow_out;
      assign w_shadow_vld_in = g_lane[k-1].w_shadow_vld_out;
    end

    rvfi_mon_lane_check u_lane_check (
      .i_lane       (w_lane[k]),
      .i_order      (w_order_in),
      .i_first      (w_first_in),
      .i_last_pc    (w_last_pc_in),
      .i_halted     (w_halted_in),
      .i_shadow     (w_shadow_in),
      .i_shadow_vld (w_shadow_vld_in),
      .o_err        (w_lane_err[k]),
      .o_order      (w_order_out),
      .o_first      (w_first_out),
      .o_last_pc    (w_last_pc_out),
      .o_halted     (w_halted_out),
      .o_shadow     (w_shadow_out),
      .o_shadow_vld (w_shadow_vld_out)
    );
  end

  // Lowest-index failing lane wins.
  always_comb begin
    w_err = ERR_NONE;
    for (int k = 0; k < NRET; k++) begin
      if (w_err == ERR_NONE) begin
        w_err = w_lane_err[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_order      <= 64'd0;
      r_first      <= 1'b1;
      r_last_pc    <= 32'd0;
      r_halted     <= 1'b0;
      r_shadow     <= '0;
      r_shadow_vld <= 32'd0;
      r_errcode    <= ERR_NONE;
    end else begin
      r_order      <= g_lane[NRET-1].w_order_out;
      r_first      <= g_lane[NRET-1].w_first_out;
      r_last_pc    <= g_lane[NRET-1].w_last_pc_out;
      r_halted     <= g_lane[NRET-1].w_halted_out;
      r_shadow     <= g_lane[NRET-1].w_shadow_out;
      r_shadow_vld <= g_lane[NRET-1].w_shadow_vld_out;
      if (r_errcode == ERR_NONE) begin
        r_errcode <= w_err;
      end
    end
  end

  assign errcode = r_errcode;

endmodule

// File: tb/tb_rvfi_monitor_rv32imc.sv
// Directed bench for the RVFI monitor with two retire lanes.
module tb_rvfi_monitor_rv32imc;

  localparam int N = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr, rvfi_mem_extamo;
  logic [64*N-1:0] rvfi_order;
  logic [32*N-1:0] rvfi_insn, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
  logic [32*N-1:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [2*N-1:0]  rvfi_mode;
  logic [5*N-1:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [4*N-1:0]  rvfi_mem_rmask, rvfi_mem_wmask;
  logic [15:0]     errcode;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  rvfi_monitor_rv32imc #(.NRET(N)) dut (
    .clock           (clock),
    .reset           (reset),
    .rvfi_valid      (rvfi_valid),
    .rvfi_order      (rvfi_order),
    .rvfi_insn       (rvfi_insn),
    .rvfi_trap       (rvfi_trap),
    .rvfi_halt       (rvfi_halt),
    .rvfi_intr       (rvfi_intr),
    .rvfi_mode       (rvfi_mode),
    .rvfi_rs1_addr   (rvfi_rs1_addr),
    .rvfi_rs2_addr   (rvfi_rs2_addr),
    .rvfi_rd_addr    (rvfi_rd_addr),
    .rvfi_rs1_rdata  (rvfi_rs1_rdata),
    .rvfi_rs2_rdata  (rvfi_rs2_rdata),
    .rvfi_rd_wdata   (rvfi_rd_wdata),
    .rvfi_pc_rdata   (rvfi_pc_rdata),
    .rvfi_pc_wdata   (rvfi_pc_wdata),
    .rvfi_mem_addr   (rvfi_mem_addr),
    .rvfi_mem_rmask  (rvfi_mem_rmask),
    .rvfi_mem_wmask  (rvfi_mem_wmask),
    .rvfi_mem_rdata  (rvfi_mem_rdata),
    .rvfi_mem_wdata  (rvfi_mem_wdata),
    .rvfi_mem_extamo (rvfi_mem_extamo),
    .errcode         (errcode)
  );

  task automatic clear_lanes();
    rvfi_valid = '0; rvfi_trap = '0; rvfi_halt = '0; rvfi_intr = '0; rvfi_mem_extamo = '0;
    rvfi_order = '0; rvfi_insn = '0; rvfi_rs1_rdata = '0; rvfi_rs2_rdata = '0;
    rvfi_rd_wdata = '0; rvfi_pc_rdata = '0; rvfi_pc_wdata = '0; rvfi_mem_addr = '0;
    rvfi_mem_rdata = '0; rvfi_mem_wdata = '0; rvfi_mode = '0; rvfi_rs1_addr = '0;
    rvfi_rs2_addr = '0; rvfi_rd_addr = '0; rvfi_mem_rmask = '0; rvfi_mem_wmask = '0;
  endtask

  task automatic set_lane(input int k, input logic [63:0] ord, input logic [31:0] pcr,
                          input logic [31:0] pcw);
    rvfi_valid[k]           = 1'b1;
    rvfi_order[k*64 +: 64]  = ord;
    rvfi_pc_rdata[k*32 +: 32] = pcr;
    rvfi_pc_wdata[k*32 +: 32] = pcw;
    rvfi_insn[k*32 +: 32]   = 32'h0000_0013;
  endtask

  task automatic set_rd(input int k, input logic [4:0] a, input logic [31:0] d);
    rvfi_rd_addr[k*5 +: 5]   = a;
    rvfi_rd_wdata[k*32 +: 32] = d;
  endtask

  task automatic set_rs1(input int k, input logic [4:0] a, input logic [31:0] d);
    rvfi_rs1_addr[k*5 +: 5]   = a;
    rvfi_rs1_rdata[k*32 +: 32] = d;
  endtask

  task automatic set_rs2(input int k, input logic [4:0] a, input logic [31:0] d);
    rvfi_rs2_addr[k*5 +: 5]   = a;
    rvfi_rs2_rdata[k*32 +: 32] = d;
  endtask

  // Clock the current lane stimulus in, then sample just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    clear_lanes();
  endtask

  task automatic check(input string tag, input logic [15:0] exp);
    n_vec++;
    assert (errcode === exp)
    else begin
      n_err++;
      $error("FAIL %s: errcode=%0d expected=%0d", tag, errcode, exp);
    end
  endtask

  task automatic do_reset();
    clear_lanes();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    clear_lanes();
    reset = 1'b0;
    tick();
    tick();
    check("reset", 16'd0);
    reset = 1'b1;

    // Clean three-instruction stream with a register write then read-back.
    set_lane(0, 64'd0, 32'h1000, 32'h1004); set_rd(0, 5'd1, 32'd5);
    tick(); check("seq0", 16'd0);
    set_lane(0, 64'd1, 32'h1004, 32'h1008); set_rs1(0, 5'd1, 32'd5);
    tick(); check("seq1", 16'd0);
    set_lane(0, 64'd2, 32'h1008, 32'h100C);
    tick(); check("seq2", 16'd0);

    // Order skip, then stickiness against a later PC break.
    do_reset();
    set_lane(0, 64'd0, 32'h1000, 32'h1004);
    tick(); check("ord_ok", 16'd0);
    set_lane(0, 64'd2, 32'h1004, 32'h1008);
    tick(); check("order", 16'd101);
    set_lane(0, 64'd3, 32'h5000, 32'h5004);
    tick(); check("sticky", 16'd101);

    do_reset();
    check("rst_clear", 16'd0);
    set_lane(0, 64'd0, 32'h1FFC, 32'h2000);
    tick(); check("pc_ok", 16'd0);
    set_lane(0, 64'd1, 32'h2004, 32'h2008);
    tick(); check("pc", 16'd102);

    do_reset();
    set_lane(0, 64'd0, 32'h0, 32'h4); set_rd(0, 5'd5, 32'hDEAD);
    tick(); check("wr_x5", 16'd0);
    set_lane(0, 64'd1, 32'h4, 32'h8); set_rs2(0, 5'd5, 32'hBEEF);
    tick(); check("rs2", 16'd104);

    // Same-cycle forwarding lane 0 -> lane 1, then a lane-0 hole, then a bad rs1.
    do_reset();
    set_lane(0, 64'd0, 32'h0, 32'h4); set_rd(0, 5'd5, 32'hDEAD);
    set_lane(1, 64'd1, 32'h4, 32'h8); set_rs2(1, 5'd5, 32'hDEAD);
    tick(); check("fwd", 16'd0);
    set_lane(1, 64'd2, 32'h8, 32'hC); set_rs1(1, 5'd5, 32'hDEAD);
    tick(); check("hole", 16'd0);
    set_lane(1, 64'd3, 32'hC, 32'h10); set_rs1(1, 5'd5, 32'h0);
    tick(); check("rs1", 16'd103);

    do_reset();
    set_lane(0, 64'd0, 32'h0, 32'h4); rvfi_mem_rmask[3:0] = 4'b0110;
    tick(); check("mask", 16'd107);

    do_reset();
    set_lane(0, 64'd0, 32'h0, 32'h4); rvfi_mem_rmask[3:0] = 4'b0011;
    rvfi_mem_wmask[3:0] = 4'b1100;
    tick(); check("mask_rw", 16'd107);

    do_reset();
    set_lane(0, 64'd0, 32'h0, 32'h4); set_rd(0, 5'd0, 32'd1);
    tick(); check("x0", 16'd105);

    do_reset();
    set_lane(0, 64'd0, 32'h0, 32'h4); rvfi_halt[0] = 1'b1;
    tick(); check("halt_ok", 16'd0);
    set_lane(0, 64'd1, 32'h4, 32'h8);
    tick(); check("halted", 16'd106);

    do_reset();
    set_lane(0, 64'd0, 32'h0, 32'h4); rvfi_halt[0] = 1'b1;
    set_lane(1, 64'd1, 32'h4, 32'h8);
    tick(); check("halt_same", 16'd106);

    do_reset();
    set_lane(0, 64'd0, 32'h1000, 32'h1001);
    tick(); check("pc_align", 16'd108);

    do_reset();
    set_lane(0, 64'd0, 32'h0, 32'h2); rvfi_insn[31:0] = 32'h0001_0001;
    tick(); check("insn", 16'd109);

    do_reset();
    set_lane(0, 64'd0, 32'h0, 32'h2); rvfi_insn[31:0] = 32'h0000_4501;
    tick(); check("rvc_ok", 16'd0);

    // Within a lane the lower code wins; across lanes the lower lane wins.
    do_reset();
    set_lane(0, 64'd7, 32'h0, 32'h4); rvfi_trap[0] = 1'b1;
    tick(); check("prio_chk", 16'd101);

    do_reset();
    set_lane(0, 64'd0, 32'h0, 32'h4); rvfi_trap[0] = 1'b1;
    set_lane(1, 64'd5, 32'h4, 32'h8);
    tick(); check("prio_lane", 16'd110);

    // After reset: any first PC is accepted and stale shadow values are forgotten.
    do_reset();
    check("rst_again", 16'd0);
    set_lane(0, 64'd0, 32'h1234_0000, 32'h1234_0004); set_rs1(0, 5'd5, 32'h0);
    tick(); check("post_rst", 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rvfi_monitor_rv32imc.md
Name: rvfi_monitor_rv32imc

Overview:
- Synthesizable-style RVFI commit-stream checker for an RV32IMC core with NRET retire channels.
- Consumes flattened RVFI buses from the core's commit stage and checks ordering, PC continuity, register-value consistency, memory-mask legality and halt discipline.
- Reports the first violation as a sticky 16-bit error code; the testbench flags any nonzero errcode.
- Full ISA-semantic checking is out of scope.

Parameters:
NRET, 1, number of retire channels; all rvfi_* buses are NRET lanes wide, lane k at bits [k*W +: W].

Ports:
clock  input  1  single clock; all state updates on posedge.
reset  input  1  synchronous, active-low reset.
rvfi_valid  input  NRET  lane commits this cycle.
rvfi_order  input  64*NRET  instruction sequence number.
rvfi_insn  input  32*NRET  instruction word.
rvfi_trap, rvfi_halt, rvfi_intr  input  NRET each  trap, halt and interrupt flags.
rvfi_mode  input  2*NRET  privilege mode; ignored.
rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  input  5*NRET each  register indices.
rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata  input  32*NRET each  register data.
rvfi_pc_rdata, rvfi_pc_wdata  input  32*NRET each  current PC and next PC.
rvfi_mem_addr  input  32*NRET  word-aligned memory address.
rvfi_mem_rmask, rvfi_mem_wmask  input  4*NRET each  byte masks.
rvfi_mem_rdata, rvfi_mem_wdata  input  32*NRET each  memory data.
rvfi_mem_extamo  input  NRET  ignored.
errcode  output  16  0 = no error; otherwise the first error code (sticky).

Behaviour:
- Reset (reset==0 at posedge):
  - errcode = 0; expected_order = 0; first_commit = 1; halted = 0.
  - All 32 shadow-register valid bits cleared.
- Lane processing order:
  - Lanes are processed in ascending index order within a cycle, combinationally chained.
  - Lane k sees the state updates of valid lanes < k: order, last pc_wdata, shadow register writes, halt.
  - Invalid lanes are skipped, and holes between valid lanes are allowed.
- Per valid lane checks. Priority is lowest code first; only the first failing lane/check of a cycle is recorded:
  - 101: order != expected_order.
  - 102: !first_commit and pc_rdata != previous committed pc_wdata.
  - 103: rs1_addr!=0, shadow[rs1] valid, and rs1_rdata != shadow[rs1].
  - 104: same rule as 103 for rs2.
  - 105: rd_addr==0 and rd_wdata!=0; or rs1_addr==0 and rs1_rdata!=0; or rs2_addr==0 and rs2_rdata!=0.
  - 106: commit while halted (includes later lanes in the same cycle as the halt).
  - 107: rmask and wmask both nonzero; or a nonzero mask not in {0001,0010,0100,1000,0011,1100,1111}.
  - 108: pc_rdata[0] or pc_wdata[0] set.
  - 109: insn[1:0]!=2'b11 and insn[31:16]!=0.
  - 110: trap==1.
- Per valid lane updates, applied regardless of errors:
  - expected_order = order+1.
  - last_pc = pc_wdata; first_commit = 0.
  - If rd_addr!=0: shadow[rd] = rd_wdata and shadow[rd] marked valid.
  - halted |= halt.
- errcode:
  - Registered, one cycle latency: a violation at posedge N shows on errcode after posedge N.
  - Written only while errcode==0; holds until reset.
- rvfi_intr, rvfi_mode, rvfi_mem_extamo, mem_addr, mem_rdata and mem_wdata are not checked.
- A 64-bit order compare is required; no wrap handling.

Decomposition:
- Package rvfi_mon_pkg holds:
  - the errcode localparams (ERR_NONE=0, ERR_ORDER=101 … ERR_TRAP=110);
  - the legal-mask function;
  - a per-lane unpacked struct typedef.
- One sub-module, rvfi_mon_lane_check: combinational single-lane check.
  - Inputs: lane signals plus incoming state.
  - Outputs: error code and updated state.
  - Chained NRET times in a generate loop.

Test Plan:
- Reset low, then 3 sequential commits (order 0,1,2; pc 0x1000→0x1004→0x1008→0x100C; addi x1 wdata 5, then read rs1=x1 rdata 5) -> errcode stays 0.
- Second commit with order 2 instead of 1 -> errcode = 101 one cycle later; it stays 101 even if a later commit has bad pc.
- Commit pc_wdata 0x2000, next pc_rdata 0x2004 -> 102.
- Write x5=0xDEAD; later commit rs2=x5 with rs2_rdata 0xBEEF -> 104. With NRET=2, a lane-0 write of x5 and a lane-1 read of x5 with the new value in the same cycle -> 0.
- Commit with rmask=4'b0110 -> 107. rd_addr=0 with rd_wdata=1 -> 105. Halt commit followed by any valid commit -> 106.
- Drive an error, then reset low for one cycle -> errcode 0; the first commit after reset with order 0 and any pc -> no error.
